// File: rtl/vga_sram_arbiter_pkg.sv
// Shared types for the VGA SRAM arbiter: FSM state encoding, SRAM strobe bundle
// and the strobe pattern that goes with each access state.
package vga_sram_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    TURN = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic ub_n;
    logic lb_n;
    logic dq_oe;
  } sram_ctrl_t;

  localparam sram_ctrl_t CTRL_IDLE = sram_ctrl_t'(6'b11111_0);

  // Pin pattern driven while the FSM sits in state s (IDLE and TURN park the bus).
  function automatic sram_ctrl_t ctrl_for(input arb_state_e s);
    sram_ctrl_t c;
    c = CTRL_IDLE;
    case (s)
      RD: begin
        c.ce_n = 1'b0;
        c.oe_n = 1'b0;
        c.ub_n = 1'b0;
        c.lb_n = 1'b0;
      end
      WR: begin
        c.ce_n  = 1'b0;
        c.we_n  = 1'b0;
        c.ub_n  = 1'b0;
        c.lb_n  = 1'b0;
        c.dq_oe = 1'b1;
      end
      default: c = CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_sram_arbiter_streak_ctr.sv
// Saturating count of read grants issued while a write waits; raises o_force_wr
// once the limit is reached so the waiting writer wins the next decision.
module arb_streak_ctr #(
  parameter int MAX_RD_STREAK = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_wr_req,
  input  logic i_rd_gnt,
  input  logic i_wr_gnt,
  output logic o_force_wr
);

  localparam int CW = $clog2(MAX_RD_STREAK + 1);
  localparam logic [CW-1:0] STREAK_MAX = CW'(MAX_RD_STREAK);

  logic [CW-1:0] streak_q, streak_d;

  always_comb begin
    streak_d = streak_q;
    if (!i_wr_req || i_wr_gnt) begin
      streak_d = '0;
    end else if (i_rd_gnt && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign o_force_wr = i_wr_req && (streak_q == STREAK_MAX);

endmodule

// File: rtl/vga_sram_arbiter.sv
// Read-priority arbiter sharing one async SRAM between the display fetch and the
// framebuffer writer. Optional statistics ports: define VGA_SRAM_ARB_STATS_EN.
module vga_sram_arbiter
  import vga_sram_pkg::*;
#(
  parameter int ADDR_W        = SRAM_ADDR_W,
  parameter int DATA_W        = SRAM_DATA_W,
  parameter int MAX_RD_STREAK = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_gnt,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_gnt,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_dq,
  output logic              o_sram_dq_oe,
  input  logic [DATA_W-1:0] i_sram_dq,
`ifdef VGA_SRAM_ARB_STATS_EN
  output logic [15:0]       o_starve_cnt,
  output logic [7:0]        o_override_cnt,
`endif
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_sram_ub_n,
  output logic              o_sram_lb_n
);

  arb_state_e        state_q, state_d;
  sram_ctrl_t        ctrl_q, ctrl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dq_q, dq_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_gnt, wr_gnt;
  logic              force_wr;

  arb_streak_ctr #(
    .MAX_RD_STREAK (MAX_RD_STREAK)
  ) u_streak (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr_req   (i_wr_req),
    .i_rd_gnt   (rd_gnt),
    .i_wr_gnt   (wr_gnt),
    .o_force_wr (force_wr)
  );

  // Grants are combinational so a requester can drop req on the very edge it is
  // served; the WR cycle is the only one in which no decision is taken.
  always_comb begin
    rd_gnt     = 1'b0;
    wr_gnt     = 1'b0;
    state_d    = IDLE;
    addr_d     = addr_q;
    dq_d       = dq_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;

    if (!i_rst && (state_q != WR)) begin
      if (i_rd_req && !force_wr) begin
        rd_gnt = 1'b1;
      end else if (i_wr_req) begin
        wr_gnt = 1'b1;
      end
    end

    if (rd_gnt) begin
      state_d = RD;
      addr_d  = i_rd_addr;
    end else if (wr_gnt) begin
      state_d = WR;
      addr_d  = i_wr_addr;
      dq_d    = i_wr_data;
    end else if (state_q == WR) begin
      state_d = TURN;
    end

    if (state_q == RD) begin
      rd_valid_d = 1'b1;
      rd_data_d  = i_sram_dq;
    end

    ctrl_d = ctrl_for(state_d);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      ctrl_q     <= CTRL_IDLE;
      addr_q     <= '0;
      dq_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      addr_q     <= addr_d;
      dq_q       <= dq_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef VGA_SRAM_ARB_STATS_EN
  logic [15:0] starve_q, starve_d;
  logic [7:0]  override_q, override_d;

  // A write grant while a read is also asking can only come from a saturated streak.
  always_comb begin
    starve_d   = starve_q;
    override_d = override_q;
    if (rd_gnt && i_wr_req && (starve_q != 16'hFFFF)) begin
      starve_d = starve_q + 16'd1;
    end
    if (wr_gnt && i_rd_req) begin
      override_d = override_q + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      starve_q   <= '0;
      override_q <= '0;
    end else begin
      starve_q   <= starve_d;
      override_q <= override_d;
    end
  end

  assign o_starve_cnt   = starve_q;
  assign o_override_cnt = override_q;
`endif

  assign o_rd_gnt     = rd_gnt;
  assign o_wr_gnt     = wr_gnt;
  assign o_rd_valid   = rd_valid_q;
  assign o_rd_data    = rd_data_q;
  assign o_sram_addr  = addr_q;
  assign o_sram_dq    = dq_q;
  assign o_sram_dq_oe = ctrl_q.dq_oe;
  assign o_sram_ce_n  = ctrl_q.ce_n;
  assign o_sram_oe_n  = ctrl_q.oe_n;
  assign o_sram_we_n  = ctrl_q.we_n;
  assign o_sram_ub_n  = ctrl_q.ub_n;
  assign o_sram_lb_n  = ctrl_q.lb_n;

endmodule

// File: tb/tb_vga_sram_arbiter.sv
// Directed + random bench for vga_sram_arbiter against a cycle-level model of the
// grant rules, read latency and pin behaviour, with a behavioural SRAM attached.
module tb_vga_sram_arbiter;

  localparam int MAXS = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req, wr_req;
  logic [19:0] rd_addr, wr_addr;
  logic [15:0] wr_data;
  logic        rd_gnt, wr_gnt, rd_valid;
  logic [15:0] rd_data;
  logic [19:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        dq_oe, ce_n, oe_n, we_n, ub_n, lb_n;
`ifdef VGA_SRAM_ARB_STATS_EN
  logic [15:0] starve_cnt;
  logic [7:0]  override_cnt;
`endif

  always #5 clk = ~clk;

  vga_sram_arbiter #(.ADDR_W(20), .DATA_W(16), .MAX_RD_STREAK(MAXS)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_gnt(rd_gnt),
    .o_rd_valid(rd_valid), .o_rd_data(rd_data),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_gnt(wr_gnt),
    .o_sram_addr(sram_addr), .o_sram_dq(sram_dq_out), .o_sram_dq_oe(dq_oe),
    .i_sram_dq(sram_dq_in),
`ifdef VGA_SRAM_ARB_STATS_EN
    .o_starve_cnt(starve_cnt), .o_override_cnt(override_cnt),
`endif
    .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n),
    .o_sram_ub_n(ub_n), .o_sram_lb_n(lb_n)
  );

  // Behavioural async SRAM (1K words used); unwritten words read a fill pattern.
  function automatic logic [15:0] fill(input logic [9:0] a);
    return {a[5:0], a} ^ 16'h5A5A;
  endfunction

  bit [15:0]   sram [1024];
  bit          written [1024];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_a = '0;
  logic [15:0] pl_d = '0;

  always @(posedge clk) begin
    if (pl_en) begin
      sram[pl_a]    <= pl_d;
      written[pl_a] <= 1'b1;
    end else if (!ce_n && !we_n && dq_oe) begin
      sram[sram_addr[9:0]]    <= sram_dq_out;
      written[sram_addr[9:0]] <= 1'b1;
    end
  end

  assign sram_dq_in = (!ce_n && !oe_n && !dq_oe)
                    ? (written[sram_addr[9:0]] ? sram[sram_addr[9:0]] : fill(sram_addr[9:0]))
                    : 16'hDEAD;

  // Reference model state
  typedef struct {
    int          due;
    logic [15:0] data;
  } rdq_t;

  rdq_t        rq[$];
  logic [15:0] model_mem [1024];
  int          m_streak, cyc;
  logic        m_blocked, m_prev_rd, m_prev_wr;
  logic [19:0] m_addr;
  logic [15:0] m_dq, m_rd_data;
  logic        last_erd, last_ewr, obs_rd, obs_wr, obs_valid;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    logic       erd, ewr, ev, acc;
    logic [5:0] ectrl;
    rdq_t       e;
    @(negedge clk);
    erd = 1'b0;
    ewr = 1'b0;
    if (!rst && !m_blocked) begin
      if (rd_req && !(wr_req && m_streak == MAXS)) erd = 1'b1;
      else if (wr_req) ewr = 1'b1;
    end
    ev = (rq.size() > 0) && (rq[0].due == cyc);
    if (ev) begin
      m_rd_data = rq[0].data;
      void'(rq.pop_front());
    end
    acc   = m_prev_rd || m_prev_wr;
    ectrl = {!acc, !m_prev_rd, !m_prev_wr, !acc, !acc, m_prev_wr};

    chk("rd_gnt", {31'd0, rd_gnt}, {31'd0, erd});
    chk("wr_gnt", {31'd0, wr_gnt}, {31'd0, ewr});
    chk("strobes", {26'd0, ce_n, oe_n, we_n, ub_n, lb_n, dq_oe}, {26'd0, ectrl});
    chk("sram_addr", {12'd0, sram_addr}, {12'd0, m_addr});
    chk("sram_dq", {16'd0, sram_dq_out}, {16'd0, m_dq});
    chk("rd_valid", {31'd0, rd_valid}, {31'd0, ev});
    chk("rd_data", {16'd0, rd_data}, {16'd0, m_rd_data});
    chk("bus_clash", {31'd0, dq_oe & ~oe_n}, 32'd0);

    obs_rd    = rd_gnt;
    obs_wr    = wr_gnt;
    obs_valid = rd_valid;
    if (erd) $display("cyc %0d: read grant  addr=%05h", cyc, rd_addr);
    if (ewr) $display("cyc %0d: write grant addr=%05h data=%04h", cyc, wr_addr, wr_data);
    if (ev)  $display("cyc %0d: read data   %04h", cyc, m_rd_data);

    if (rst) begin
      rq.delete();
      m_streak  = 0;
      m_blocked = 1'b0;
      m_prev_rd = 1'b0;
      m_prev_wr = 1'b0;
      m_addr    = '0;
      m_dq      = '0;
      m_rd_data = '0;
    end else begin
      if (erd) begin
        e.due  = cyc + 2;
        e.data = model_mem[rd_addr[9:0]];
        rq.push_back(e);
        m_addr = rd_addr;
      end
      if (ewr) begin
        model_mem[wr_addr[9:0]] = wr_data;
        m_addr = wr_addr;
        m_dq   = wr_data;
      end
      if (!wr_req || ewr) m_streak = 0;
      else if (erd && m_streak < MAXS) m_streak++;
      m_blocked = ewr;
      m_prev_rd = erd;
      m_prev_wr = ewr;
    end
    last_erd = erd;
    last_ewr = ewr;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          nrd, nwr;
    logic        got_w;
    logic [7:0]  ovr_before;

    for (int i = 0; i < 1024; i++) model_mem[i] = fill(10'(i));
    m_streak = 0; m_blocked = 0; m_prev_rd = 0; m_prev_wr = 0;
    m_addr = '0; m_dq = '0; m_rd_data = '0; cyc = 0;
    ovr_before = '0;
    rst = 1'b1; rd_req = 1'b1; wr_req = 1'b0;
    rd_addr = 20'h00001; wr_addr = '0; wr_data = '0;
    pl_en = 1'b1; pl_a = 10'h123; pl_d = 16'hBEEF;
    model_mem[10'h123] = 16'hBEEF;
    @(posedge clk);
    #1;
    pl_en = 1'b0;

    // 1: reset held with rd_req high, then first grant right after release
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;
    tick();
    chk("first_gnt", {31'd0, obs_rd}, 32'd1);
    rd_req = 1'b0;
    tick(); tick(); tick();

    // 2: single read of 0x00123
    rd_req = 1'b1; rd_addr = 20'h00123;
    tick();
    rd_req = 1'b0;
    tick(); tick();
    chk("single_rd_valid", {31'd0, obs_valid}, 32'd1);
    chk("single_rd_data", {16'd0, rd_data}, 32'h0000BEEF);

    // 3: write 0xA5A5 to 0x00010 then read it back
    wr_req = 1'b1; wr_addr = 20'h00010; wr_data = 16'hA5A5;
    tick();
    wr_req = 1'b0; rd_req = 1'b1; rd_addr = 20'h00010;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (last_erd) rd_req = 1'b0;
    end
    chk("wr_then_rd", {16'd0, rd_data}, 32'h0000A5A5);

    // 4: starvation guard
`ifdef VGA_SRAM_ARB_STATS_EN
    ovr_before = override_cnt;
`endif
    rd_req = 1'b1; wr_req = 1'b1; wr_addr = 20'h00222; wr_data = 16'h1234;
    nrd = 0; got_w = 1'b0;
    for (int i = 0; i < 40 && !got_w; i++) begin
      tick();
      if (obs_rd) begin nrd++; rd_addr = 20'($urandom_range(0, 1023)); end
      if (obs_wr) got_w = 1'b1;
    end
    chk("starve_wr_seen", {31'd0, got_w}, 32'd1);
    chk("starve_rd_count", nrd, MAXS);
    wr_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
`ifdef VGA_SRAM_ARB_STATS_EN
    chk("override_inc", {24'd0, override_cnt}, {24'd0, ovr_before + 8'd1});
`endif
    rd_req = 1'b0;
    tick(); tick(); tick();

    // 5: contention throughput over 100 cycles
    rd_req = 1'b1; wr_req = 1'b1;
    nrd = 0; nwr = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (obs_rd) begin nrd++; rd_addr = 20'($urandom_range(0, 1023)); end
      if (obs_wr) begin nwr++; wr_addr = 20'($urandom_range(0, 1023)); wr_data = 16'($urandom); end
    end
    chk("contention_rd", {31'd0, (nrd >= 79 && nrd <= 81)}, 32'd1);
    chk("contention_wr", {31'd0, (nwr >= 9 && nwr <= 11)}, 32'd1);
    rd_req = 1'b0; wr_req = 1'b0;
    tick(); tick(); tick(); tick();

    // 6: reset during the RD cycle kills the pending valid
    rd_req = 1'b1; rd_addr = 20'h00123;
    tick();
    rd_req = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_mid_rd_novalid", {31'd0, obs_valid}, 32'd0);
`ifdef VGA_SRAM_ARB_STATS_EN
    chk("starve_cnt_clr", {16'd0, starve_cnt}, 32'd0);
    chk("override_cnt_clr", {24'd0, override_cnt}, 32'd0);
`endif

    // Random traffic with held requests, occasional drops and resets
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (last_erd || !rd_req) begin
        rd_req  = ($urandom_range(0, 99) < 60);
        rd_addr = 20'($urandom_range(0, 1023));
      end else if ($urandom_range(0, 49) == 0) begin
        rd_req = 1'b0;
      end
      if (last_ewr || !wr_req) begin
        wr_req  = ($urandom_range(0, 99) < 40);
        wr_addr = 20'($urandom_range(0, 1023));
        wr_data = 16'($urandom);
      end else if ($urandom_range(0, 49) == 0) begin
        wr_req = 1'b0;
      end
      tick();
    end
    rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_sram_arbiter.md
Name: vga_sram_arbiter

Overview:
- Shares the single 16-bit off-chip SRAM between two requesters, runs in the 25.2 MHz pixel clock domain.
- Requester 0 is the display line-fetch reader feeding the VGA pixel path; requester 1 is the framebuffer writer (draw engine, key-driven).
- Reads have priority. A streak limit prevents writer starvation.
- Owns all SRAM control pins and the DQ tristate enable.

Parameters:
- ADDR_W, 20, SRAM word address width.
- DATA_W, 16, SRAM data width.
- MAX_RD_STREAK, 8, consecutive read grants allowed while a write is pending; must be ≥1.

Ports:
- i_clk  in  1  pixel clock (25.2 MHz).
- i_rst  in  1  reset; one clock, synchronous, active-high.
- i_rd_req  in  1  display read request, held until granted.
- i_rd_addr  in  ADDR_W  read address, sampled on grant.
- o_rd_gnt  out  1  one-cycle read grant pulse.
- o_rd_valid  out  1  one-cycle pulse; o_rd_data valid.
- o_rd_data  out  DATA_W  registered read data.
- i_wr_req  in  1  writer request, held until granted.
- i_wr_addr  in  ADDR_W  write address, sampled on grant.
- i_wr_data  in  DATA_W  write data, sampled on grant.
- o_wr_gnt  out  1  one-cycle write grant pulse.
- o_sram_addr  out  ADDR_W  SRAM address.
- o_sram_dq  out  DATA_W  write data to pad.
- o_sram_dq_oe  out  1  pad output enable; top assigns high-Z when low.
- i_sram_dq  in  DATA_W  pad input data.
- o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_ub_n, o_sram_lb_n  out  1 each  SRAM strobes, active-low.

Behaviour:
- Reset values:
  - All grants and valids 0; o_rd_data 0; o_sram_addr 0; o_sram_dq_oe 0.
  - ce_n=1, oe_n=1, we_n=1, ub_n=1, lb_n=1.
  - Streak counter 0; state IDLE.
- FSM states: IDLE, RD, WR, TURN. The arbitration decision is made in IDLE, RD and TURN on the current request lines.
- Decision rule:
  - If rd_req and NOT (wr_req and streak==MAX_RD_STREAK): grant read.
  - Else if wr_req: grant write.
  - Else go to IDLE.
- Grant cycle:
  - The grant pulse is asserted and the address (and write data) are registered into the SRAM pins.
  - Next state is RD or WR.
- RD:
  - ce_n=0, oe_n=0, ub_n=lb_n=0, dq_oe=0.
  - i_sram_dq is registered into o_rd_data at the end of RD.
  - o_rd_valid=1 in the following cycle. Latency is 2 cycles from o_rd_gnt.
  - Back-to-back reads are allowed: RD→RD, one word per cycle sustained.
- WR:
  - ce_n=0, we_n=0, ub_n=lb_n=0, dq_oe=1, o_sram_dq=latched data.
  - Next state is always TURN.
- TURN:
  - dq_oe=0, we_n=1, oe_n=1 (bus turnaround).
  - The arbiter may grant in this cycle; it starts the next access after TURN.
- Streak counter:
  - Increments on each read grant while wr_req=1; saturates at MAX_RD_STREAK.
  - Clears on a write grant, or whenever wr_req=0.
- Simultaneous requests: read wins unless the streak is saturated.
- No request may be granted while a grant is already outstanding in the same cycle; at most one grant pulse per cycle.
- Requester dropping req before grant: allowed; no grant is issued.
- Reset mid-access:
  - Outputs return to reset values the next edge.
  - A pending o_rd_valid is suppressed.
  - dq_oe drops immediately after the reset edge.

Optional Feature:
- Macro: VGA_SRAM_ARB_STATS_EN.
- Defined:
  - Adds output o_starve_cnt[15:0]. It increments on every cycle where wr_req=1 and a read was granted, and saturates at 16'hFFFF.
  - Adds output o_override_cnt[7:0], counting forced write grants due to a saturated streak (wraps).
  - Both counters clear on i_rst.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package vga_sram_pkg holds:
  - arb_state_e enum {IDLE, RD, WR, TURN};
  - localparams SRAM_ADDR_W=20 and SRAM_DATA_W=16;
  - typedef sram_ctrl_t, a struct of the five strobes plus dq_oe.
- Sub-module arb_streak_ctr holds the saturating streak counter and the override decision. It is small but reused by the planned audio/VGA second arbiter.

Test Plan:
1. Reset: assert i_rst 3 cycles with rd_req=1 → no grants; all strobes 1; dq_oe=0. The first read grant arrives the cycle after i_rst drops.
2. Single read: rd_req with addr 0x00123, SRAM model returns 0xBEEF → o_rd_gnt at T, RD at T+1 with addr 0x00123, o_rd_valid with 0xBEEF at T+2.
3. Write then read: wr_req (0x00010, 0xA5A5) then rd_req of the same address → WR, TURN, then RD. o_rd_data=0xA5A5. dq_oe is never 1 in the same cycle as oe_n=0.
4. Starvation: rd_req held continuously, wr_req raised, MAX_RD_STREAK=8 → exactly 8 read grants, then 1 write grant. The streak clears and reads resume after TURN.
5. Contention throughput: 100 cycles, both reqs held, MAX_RD_STREAK=8 → grant pattern repeats 8R,1W with TURN. Grant counts are 80 read and 10 write (±1 at the boundaries).
6. Reset mid-read: i_rst asserted in the RD cycle → no o_rd_valid pulse. With VGA_SRAM_ARB_STATS_EN defined, o_starve_cnt and o_override_cnt read 0.
